// File: rtl/ahb_load_manager.sv
// AHB-Lite manager that loads and reads back the accelerator's word space.
// It accepts one command, then runs one non-overlapped SINGLE transfer per beat.
//
// Handshakes:
//   cmd:  a command transfers on a clk edge where cmd_valid & cmd_ready are both 1.
//         cmd_ready is high only in IDLE.
//   wr:   a word transfers on a clk edge where wr_valid & wr_ready are both 1.
//         wr_ready is high only in FETCH.
//   rd:   rd_valid is a one-cycle pulse with no back-pressure.
//         rd_data holds the value until the next read beat completes.
module ahb_load_manager #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 8,
  parameter int TIMEOUT    = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [1:0]            cmd_size,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic                  err,
  output logic                  timeout,
  output logic                  hsel,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic [1:0]            hsize,
  output logic                  hwrite,
  output logic [DATA_WIDTH-1:0] hwdata,
  output logic [2:0]            hburst,
  input  logic [DATA_WIDTH-1:0] hrdata,
  input  logic                  hresp,
  input  logic                  hready,
  output logic [2:0]            dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ADDR  = 3'd2,
    S_DATA  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              size_q, size_d;
  logic                    write_q, write_d;
  logic [LEN_WIDTH-1:0]    remain_q, remain_d;
  logic [DATA_WIDTH-1:0]   hwdata_q, hwdata_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    err_q, err_d;
  logic                    tmo_q, tmo_d;
  logic                    pend_q, pend_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic                    bus_wait;

  // State and datapath registers; reset abandons any beat in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      write_q    <= 1'b0;
      remain_q   <= '0;
      hwdata_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
      pend_q     <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      write_q    <= write_d;
      remain_q   <= remain_d;
      hwdata_q   <= hwdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      pend_q     <= pend_d;
      tcnt_q     <= tcnt_d;
    end
  end

  // Next-state and datapath updates for the command/beat sequencer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    write_d    = write_q;
    remain_d   = remain_q;
    hwdata_d   = hwdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = err_q;
    tmo_d      = tmo_q;
    pend_d     = pend_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d   = cmd_addr;
          size_d   = cmd_size;
          write_d  = cmd_write;
          remain_d = cmd_len;
          err_d    = 1'b0;
          tmo_d    = 1'b0;
          pend_d   = 1'b0;
          if (cmd_len == '0)  state_d = S_DONE;
          else if (cmd_write) state_d = S_FETCH;
          else                state_d = S_ADDR;
        end
      end
      S_FETCH: begin
        if (wr_valid) begin
          hwdata_d = wr_data;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        pend_d = 1'b0;
        if (hready) begin
          state_d = S_DATA;
        end else if (tcnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DATA: begin
        if (hready) begin
          if (!write_q) begin
            rd_data_d  = hrdata;
            rd_valid_d = 1'b1;
          end
          // hresp may be high only on the completing edge of a short response.
          if (pend_q || hresp) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            remain_d = remain_q - LEN_WIDTH'(1);
            addr_d   = addr_q + ADDR_WIDTH'(1);
            if (remain_q == LEN_WIDTH'(1)) state_d = S_DONE;
            else if (write_q)              state_d = S_FETCH;
            else                           state_d = S_ADDR;
          end
        end else begin
          if (hresp) pend_d = 1'b1;
          if (tcnt_q == TMO_LAST) begin
            err_d   = 1'b1;
            tmo_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Wait-state counter: cleared on every state change, counts stalled bus cycles.
  always_comb begin
    bus_wait = ((state_q == S_ADDR) || (state_q == S_DATA)) && !hready;
    tcnt_d   = tcnt_q;
    if (state_d != state_q) tcnt_d = '0;
    else if (bus_wait)      tcnt_d = tcnt_q + TW'(1);
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign wr_ready  = (state_q == S_FETCH);
  assign done      = (state_q == S_DONE);
  assign hsel      = (state_q == S_ADDR);
  assign htrans    = (state_q == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hburst    = 3'b000;
  assign haddr     = addr_q;
  assign hsize     = size_q;
  assign hwrite    = write_q;
  assign hwdata    = hwdata_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign err       = err_q;
  assign timeout   = tmo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_load_manager.sv
// Directed bench for ahb_load_manager with a cycle-stepped AHB subordinate.
module tb_ahb_load_manager;

  localparam int AW = 10;
  localparam int DW = 64;
  localparam int LW = 8;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [1:0]    cmd_size;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          done, err, timeout;
  logic          hsel, hwrite;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans, hsize;
  logic [DW-1:0] hwdata, hrdata;
  logic [2:0]    hburst;
  logic          hresp, hready;
  logic [2:0]    dbg_state;

  ahb_load_manager #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT(512)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .err(err), .timeout(timeout),
    .hsel(hsel), .haddr(haddr), .htrans(htrans), .hsize(hsize), .hwrite(hwrite),
    .hwdata(hwdata), .hburst(hburst),
    .hrdata(hrdata), .hresp(hresp), .hready(hready),
    .dbg_state(dbg_state)
  );

  // Scoreboard
  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] exp_q[$];

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    expect_eq({name, ":hsel"},      hsel, 0);
    expect_eq({name, ":htrans"},    htrans, 0);
    expect_eq({name, ":haddr"},     haddr, 0);
    expect_eq({name, ":hwdata"},    hwdata, 0);
    expect_eq({name, ":hwrite"},    hwrite, 0);
    expect_eq({name, ":hsize"},     hsize, 0);
    expect_eq({name, ":hburst"},    hburst, 0);
    expect_eq({name, ":rd_valid"},  rd_valid, 0);
    expect_eq({name, ":rd_data"},   rd_data, 0);
    expect_eq({name, ":done"},      done, 0);
    expect_eq({name, ":err"},       err, 0);
    expect_eq({name, ":timeout"},   timeout, 0);
    expect_eq({name, ":cmd_ready"}, cmd_ready, 1);
    expect_eq({name, ":wr_ready"},  wr_ready, 0);
    expect_eq({name, ":state"},     dbg_state, 0);
  endtask

  // Driver: issue one command and play the subordinate until done, reset or budget.
  // Cycle numbers count the accept edge as cycle 0.
  task automatic run_cmd(input string name, input bit wr, input logic [AW-1:0] a,
                         input logic [LW-1:0] n, input logic [DW-1:0] wbase,
                         input logic [DW-1:0] wstep, input logic [DW-1:0] rbase,
                         input int waits, input int err_beat, input bit stuck,
                         input int rst_beat, input int exp_done, input int exp_beats,
                         input int exp_words, input bit exp_err, input bit exp_tmo);
    int cyc, beat, wcnt, words, naddr, done_cyc, last_hsel;
    bit in_data, aborted;
    logic [AW-1:0] ea;
    exp_q.delete();
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_size = 2'b11; cmd_len = n;
    wr_valid = 1'b1; wr_data = wbase; hready = 1'b1; hresp = 1'b0;
    tick();
    cmd_valid = 1'b0;
    cyc = 1; beat = 0; wcnt = 0; words = 0; naddr = 0; done_cyc = -1; last_hsel = -1;
    in_data = 1'b0; aborted = 1'b0;
    while (cyc <= 700 && done_cyc < 0 && !aborted) begin
      hready = 1'b1;
      hresp  = 1'b0;
      hrdata = rbase + 64'(beat);
      wr_data = wbase + 64'(words) * wstep;
      if (wr_ready && wr_valid) words++;
      if (rd_valid) begin
        if (exp_q.size() == 0) expect_eq({name, ":rd_extra"}, 1, 0);
        else expect_eq({name, ":rd_data"}, rd_data, exp_q.pop_front());
      end
      if (done) begin
        done_cyc = cyc;
        expect_eq({name, ":hsel_at_done"}, hsel, 0);
        expect_eq({name, ":htrans_at_done"}, htrans, 0);
        if (!wr && !exp_err && n != 0) expect_eq({name, ":rd_valid_at_done"}, rd_valid, 1);
      end
      if (hsel) begin
        last_hsel = cyc;
        if (stuck) begin
          hready = 1'b0;
        end else begin
          ea = a + AW'(beat);
          expect_eq({name, ":haddr"},  haddr, ea);
          expect_eq({name, ":hwrite"}, hwrite, wr);
          expect_eq({name, ":htrans"}, htrans, 2'b10);
          expect_eq({name, ":hsize"},  hsize, 2'b11);
          expect_eq({name, ":hburst"}, hburst, 3'b000);
          naddr++;
          in_data = 1'b1;
          wcnt = 0;
        end
      end else if (in_data) begin
        if (beat == rst_beat) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          check_reset_outputs({name, ":after_rst"});
          aborted = 1'b1;
        end else begin
          ea = a + AW'(beat);
          expect_eq({name, ":haddr_data"}, haddr, ea);
          if (wr) expect_eq({name, ":hwdata"}, hwdata, wbase + 64'(beat) * wstep);
          if (beat == err_beat) begin
            hresp = 1'b1;
            if (wcnt == 0) begin
              hready = 1'b0;
              wcnt++;
            end else begin
              in_data = 1'b0;
              beat++;
            end
          end else if (wcnt < waits) begin
            hready = 1'b0;
            wcnt++;
          end else begin
            if (!wr) exp_q.push_back(rbase + 64'(beat));
            in_data = 1'b0;
            beat++;
          end
        end
      end
      if (!aborted) begin
        tick();
        cyc++;
      end
    end
    hready = 1'b1;
    hresp  = 1'b0;
    expect_eq({name, ":done_cycle"}, 64'(done_cyc), 64'(exp_done));
    expect_eq({name, ":beats"},      64'(naddr), 64'(exp_beats));
    expect_eq({name, ":words"},      64'(words), 64'(exp_words));
    expect_eq({name, ":err"},        err, exp_err);
    expect_eq({name, ":timeout"},    timeout, exp_tmo);
    expect_eq({name, ":rd_pending"}, 64'(exp_q.size()), 0);
    if (stuck) expect_eq({name, ":last_hsel_cycle"}, 64'(last_hsel), 512);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; hrdata = '0; hresp = 1'b0; hready = 1'b1;
    tick();
    tick();
    check_reset_outputs("por");
    rst = 1'b0;
    tick();

    //       name          wr  addr    len  wbase                  wstep  rbase                  wait errb stuck rstb done beats words err tmo
    run_cmd("wr8",         1, 10'h000, 8, 64'h0101_0101_0101_0101, 64'h0, 64'h0,                  0,  -1,  0,   -1,  25,  8,   8,    0,  0);
    run_cmd("rd_wait",     0, 10'h023, 1, 64'h0,                  64'h0, 64'h0909_0909_0909_0909, 3,  -1,  0,   -1,  6,   1,   0,    0,  0);
    run_cmd("wr_err",      1, 10'h010, 4, 64'hA000_0000_0000_0000, 64'h1, 64'h0,                  0,   1,  0,   -1,  8,   2,   2,    1,  0);
    run_cmd("rd3",         0, 10'h200, 3, 64'h0,                  64'h0, 64'hC0DE_0000_0000_0000, 0,  -1,  0,   -1,  7,   3,   0,    0,  0);
    run_cmd("rd_timeout",  0, 10'h100, 2, 64'h0,                  64'h0, 64'h0,                  0,  -1,  1,   -1,  513, 0,   0,    1,  1);
    run_cmd("len0",        1, 10'h155, 0, 64'h0,                  64'h0, 64'h0,                  0,  -1,  0,   -1,  1,   0,   0,    0,  0);
    run_cmd("wr_wrap",     1, 10'h3FF, 2, 64'h5555_0000_0000_0000, 64'h10, 64'h0,                 2,  -1,  0,   -1,  11,  2,   2,    0,  0);
    run_cmd("wr_rst",      1, 10'h040, 8, 64'h7700_0000_0000_0000, 64'h1, 64'h0,                  0,  -1,  0,    2,  -1,  3,   3,    0,  0);
    run_cmd("rd_after",    0, 10'h055, 1, 64'h0,                  64'h0, 64'hBEEF_0000_0000_1234, 0,  -1,  0,   -1,  3,   1,   0,    0,  0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
